// File: rtl/pc_sequencer.sv
// Program-counter register with internal next-PC selection and a circular
// return-address stack for redirecting procedure returns.
module pc_sequencer #(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int unsigned      RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pc_we,
   input  logic             ext_load_n,
   input  logic [WIDTH-1:0] ext_pc,
   input  logic [1:0]       pc_src,
   input  logic [WIDTH-1:0] branch_off,
   input  logic [25:0]      jump_index,
   input  logic [WIDTH-1:0] reg_target,
   input  logic             ras_push,
   input  logic             ras_pop,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] ras_top,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_overflow
);
   localparam int unsigned      PW         = $clog2(RAS_DEPTH);
   localparam int unsigned      CW         = $clog2(RAS_DEPTH + 1);
   localparam logic [CW-1:0]    FULL_COUNT = CW'(RAS_DEPTH);
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

   // ptr addresses the current top entry; valid entries sit at ptr, ptr-1, ...
   logic [WIDTH-1:0] entries [RAS_DEPTH];
   logic [PW-1:0]    ptr;
   logic [CW-1:0]    count;

   logic             ras_active;
   logic             do_push;
   logic             do_pop;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] pc_next;

   assign pc_plus4  = pc + WIDTH'(4);
   assign ras_empty = (count == '0);
   assign ras_full  = (count == FULL_COUNT);
   assign ras_top   = ras_empty ? '0 : entries[ptr];

   always_comb begin
      ras_active = pc_we & ext_load_n;
      do_push    = ras_active & ras_push;
      do_pop     = ras_active & ras_pop & ~ras_empty;
      target     = pc_plus4;
      unique case (pc_src)
         2'b00: target = pc_plus4;
         2'b01: target = pc_plus4 + (branch_off << 2);
         2'b10: target = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};
         2'b11: target = (ras_pop && !ras_empty) ? entries[ptr] : reg_target;
      endcase
      pc_next = target & ALIGN_MASK;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc           <= RESET_VECTOR;
         ptr          <= '0;
         count        <= '0;
         ras_overflow <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) entries[i] <= '0;
      end else if (!ext_load_n) begin
         pc <= ext_pc & ALIGN_MASK;
      end else if (pc_we) begin
         pc <= pc_next;
         if (do_push && do_pop) begin
            // Tail call: replace the top in place, depth unchanged.
            entries[ptr] <= pc_plus4;
         end else if (do_push) begin
            entries[ptr + PW'(1)] <= pc_plus4;
            ptr                   <= ptr + PW'(1);
            if (ras_full) ras_overflow <= 1'b1;
            else          count        <= count + CW'(1);
         end else if (do_pop) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
         end
      end
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the CPU's program-counter register.
- Holds the PC and computes the next PC internally from a 2-bit source select (sequential, branch, jump, register).
- Adds a circular return-address stack (RAS) so that procedure returns can be redirected without the register-file read.
- Sits at the head of the fetch path and drives the instruction-memory address.

Parameters:
- WIDTH, 32, PC/address width in bits; legal range 30..32.
- RESET_VECTOR, 0, PC value loaded on reset.
- RAS_DEPTH, 4, number of return-address entries; must be a power of two, 2..16.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- pc_we  input  1  PC write enable (stall when 0)
- ext_load_n  input  1  active-low external PC load (debug/boot), synchronous
- ext_pc  input  WIDTH  external PC value
- pc_src  input  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 register
- branch_off  input  WIDTH  sign-extended word offset
- jump_index  input  26  J-type instruction index
- reg_target  input  WIDTH  jump-register target (rs)
- ras_push  input  1  call: push return address
- ras_pop  input  1  return: use and pop the RAS top
- pc  output  WIDTH  current PC
- pc_plus4  output  WIDTH  pc + 4, combinational
- ras_top  output  WIDTH  current top entry; 0 when empty
- ras_empty  output  1  no valid entries
- ras_full  output  1  RAS_DEPTH valid entries
- ras_overflow  output  1  sticky; set when a push overwrites the oldest entry

Behaviour:
- Reset (reset=0, asynchronous):
  - pc = RESET_VECTOR
  - RAS count = 0 and pointer = 0, so ras_empty=1, ras_full=0, ras_top=0
  - ras_overflow = 0
  - All entries cleared to 0.
  - Reset dominates every other input.
- Update priority at each rising clk edge: reset > ext_load_n=0 > pc_we=1 > hold.
- External load (ext_load_n=0):
  - pc <= ext_pc.
  - RAS untouched; push/pop ignored.
- Hold (pc_we=0): pc, RAS and flags all unchanged; push/pop ignored.
- Next PC when pc_we=1 (all arithmetic modulo 2^WIDTH; no carry out):
  - 00: pc + 4
  - 01: pc + 4 + (branch_off << 2)
  - 10: {pc_plus4[WIDTH-1:28], jump_index, 2'b00}, truncated to WIDTH
  - 11 with ras_pop=1 and RAS non-empty: ras_top
  - 11 with ras_pop=0, or with RAS empty: reg_target
  - ras_pop with pc_src≠11 affects the stack only, not the PC.
- PC low two bits: always written as 00. Misaligned targets are silently truncated.
- Latency: one cycle; the new pc is visible the cycle after the qualifying edge. pc_plus4 is combinational from pc.
- RAS, operated only when pc_we=1 and ext_load_n=1:
  - Push only: write pc+4 at the top+1 slot. count increments, saturating at RAS_DEPTH.
  - Push when full: the oldest entry is overwritten (circular wrap), count stays at RAS_DEPTH, ras_overflow <= 1.
  - Pop only, non-empty: count decrements and the pointer retreats.
  - Pop only, empty: no change and no flag.
  - Push and pop together, non-empty: the top entry is replaced with pc+4 and count is unchanged. This is tail-call behaviour; the PC follows the pc_src rules above.
  - Push and pop together, empty: treated as push only.
- Pointer arithmetic is modulo RAS_DEPTH.
- ras_overflow clears only on reset.
- Reset asserted mid-operation: an in-flight push or pop is discarded and the state is exactly the reset state.

Test Plan:
- Reset and run:
  - Hold reset=0 with RESET_VECTOR=0x00400000 → pc=0x00400000, ras_empty=1.
  - Release reset with pc_we=1, pc_src=00 for 3 cycles → pc=0x0040000C.
- Stall and branch:
  - pc_we=0 for 2 cycles → pc unchanged.
  - Then pc_src=01, branch_off=0xFFFFFFFE at pc=0x100 → pc=0x0FC.
- Jump and external load:
  - At pc=0x10000000, pc_src=10, jump_index=0x0000040 → pc=0x10000100.
  - Then ext_load_n=0, ext_pc=0x200, pc_we=0 → pc=0x200.
- Call and return:
  - At pc=0x100, ras_push=1, pc_src=10 → ras_top=0x104.
  - Later pc_src=11, ras_pop=1, reg_target=0xDEAD0000 → pc=0x104, ras_empty=1.
  - Pop again when empty → pc=reg_target, no state change.
- Overflow wrap:
  - RAS_DEPTH=4, 5 pushes from pc=0x0,0x10,0x20,0x30,0x40 → ras_full=1, ras_overflow=1, ras_top=0x44.
  - 4 pops return 0x44,0x34,0x24,0x14, then ras_empty=1.
- Simultaneous push+pop, and async reset:
  - With top=0x104, push+pop at pc=0x300 → ras_top=0x304, count unchanged.
  - Assert reset mid-cycle → pc=RESET_VECTOR immediately without a clk edge, ras_overflow=0.
